// File: rtl/factor_judge_if.sv
// factor_judge_if: request/verdict bundle between the answer-input block
// (master) and the factor judge (slave).
`timescale 1ns/1ps
interface factor_judge_if #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_W    = 4,
  parameter int PROB_W     = 12,
  parameter int SCORE_W    = 8
);
  logic                          start;
  logic [PROB_W-1:0]             problem;
  logic [NUM_DIGITS*DIGIT_W-1:0] check;
  logic                          busy;
  logic                          done;
  logic                          verdict_ok;
  logic [1:0]                    err_code;
  logic [SCORE_W-1:0]            score;

  modport master (
    output start, problem, check,
    input  busy, done, verdict_ok, err_code, score
  );

  modport slave (
    input  start, problem, check,
    output busy, done, verdict_ok, err_code, score
  );
endinterface

// File: rtl/factor_judge.sv
// factor_judge: sequential checker for a factorization answer. Digits are
// walked most-significant first; each prime digit is multiplied into a running
// product with a DIGIT_W-cycle shift-add, and the result is compared with the
// problem number. A one-cycle done pulse carries the verdict.
// Optional macro JUDGE_SCORE_EN adds a saturating correct-verdict counter;
// without it the score output is tied to zero.
`timescale 1ns/1ps
module factor_judge #(
  parameter int NUM_DIGITS = 6,
  parameter int DIGIT_W    = 4,
  parameter int PROB_W     = 12,
  parameter int SCORE_W    = 8
) (
  input  logic         CLK,
  input  logic         RST,
  factor_judge_if.slave bus
);
  localparam int WORD_W = NUM_DIGITS * DIGIT_W;
  localparam int PROD_W = PROB_W + DIGIT_W;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BIT_W  = (DIGIT_W > 1) ? $clog2(DIGIT_W) : 1;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_PRIME   = 2'd1;
  localparam logic [1:0] ERR_FORMAT  = 2'd2;
  localparam logic [1:0] ERR_PRODUCT = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MUL, S_COMPARE, S_DONE} state_t;

  state_t              state;
  logic [WORD_W-1:0]   word_r;     // answer word, shifted left so the current digit sits on top
  logic [PROB_W-1:0]   problem_r;
  logic [PROB_W-1:0]   acc;        // running product; constant during a MUL pass
  logic [PROD_W-1:0]   prod;       // partial product of the MUL pass in progress
  logic [DIGIT_W-1:0]  prev;
  logic [DIGIT_W-1:0]  mul_d;
  logic [IDX_W-1:0]    idx;
  logic [BIT_W-1:0]    bit_i;
  logic                seen;
  logic                ovf;
  logic [1:0]          err;
  logic                busy_r;
  logic                done_r;
  logic                ok_r;
  logic [1:0]          code_r;

  logic [DIGIT_W-1:0]  cur_d;
  logic [PROD_W-1:0]   mul_term;
  logic [PROD_W-1:0]   mul_sum;
  logic                last_digit;
  logic                last_bit;

  function automatic logic is_prime_digit(input logic [DIGIT_W-1:0] d);
    int v;
    v = int'(d);
    return (v == 2) || (v == 3) || (v == 5) || (v == 7) || (v == 11) || (v == 13);
  endfunction

  // Current digit, loop-end flags and the shift-add step for this MUL cycle.
  always_comb begin
    cur_d      = word_r[WORD_W-1 -: DIGIT_W];
    last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    last_bit   = (bit_i == BIT_W'(DIGIT_W - 1));
    mul_term   = mul_d[bit_i] ? (PROD_W'(acc) << bit_i) : '0;
    mul_sum    = prod + mul_term;
  end

  // Judgement FSM; control and verdict outputs are reset, the datapath is
  // (re)loaded on every accepted start.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ok_r   <= 1'b0;
      code_r <= ERR_OK;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            word_r    <= bus.check;
            problem_r <= bus.problem;
            acc       <= PROB_W'(1);
            idx       <= '0;
            prev      <= '0;
            seen      <= 1'b0;
            ovf       <= 1'b0;
            busy_r    <= 1'b1;
            ok_r      <= 1'b0;
            code_r    <= ERR_OK;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if ((cur_d == '0) && !seen) begin
            if (last_digit) begin
              state <= S_COMPARE;
            end else begin
              idx    <= idx + 1'b1;
              word_r <= word_r << DIGIT_W;
            end
          end else if (cur_d == '0) begin
            err   <= ERR_FORMAT;
            state <= S_DONE;
          end else if (!is_prime_digit(cur_d)) begin
            err   <= ERR_PRIME;
            state <= S_DONE;
          end else if (cur_d < prev) begin
            err   <= ERR_FORMAT;
            state <= S_DONE;
          end else begin
            prev  <= cur_d;
            seen  <= 1'b1;
            mul_d <= cur_d;
            prod  <= '0;
            bit_i <= '0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          prod  <= mul_sum;
          bit_i <= bit_i + 1'b1;
          if (last_bit) begin
            acc <= mul_sum[PROB_W-1:0];
            ovf <= ovf | (|mul_sum[PROD_W-1:PROB_W]);
            if (last_digit) begin
              state <= S_COMPARE;
            end else begin
              idx    <= idx + 1'b1;
              word_r <= word_r << DIGIT_W;
              state  <= S_FETCH;
            end
          end
        end
        S_COMPARE: begin
          err   <= (!seen || ovf || (acc != problem_r)) ? ERR_PRODUCT : ERR_OK;
          state <= S_DONE;
        end
        S_DONE: begin
          done_r <= 1'b1;
          ok_r   <= (err == ERR_OK);
          code_r <= err;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.verdict_ok = ok_r;
  assign bus.err_code   = code_r;

`ifdef JUDGE_SCORE_EN
  logic [SCORE_W-1:0] score_r;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Tally correct verdicts as they are issued; only reset clears the tally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      score_r <= '0;
    end else if ((state == S_DONE) && (err == ERR_OK)) begin
      score_r <= sat_inc(score_r);
    end
  end

  assign bus.score = score_r;
`else
  assign bus.score = '0;
`endif
endmodule

// File: tb/tb_factor_judge.sv
// tb_factor_judge: table of directed vectors, busy-restart and mid-run reset
// sequences, and randomized answers checked against a digit-level model.
`timescale 1ns/1ps
module tb_factor_judge;
  localparam int NUM_DIGITS = 6;
  localparam int DIGIT_W    = 4;
  localparam int PROB_W     = 12;
  localparam int SCORE_W    = 2;
  localparam int BUDGET     = 100;
`ifdef JUDGE_SCORE_EN
  localparam int SCORE_MAX  = (1 << SCORE_W) - 1;
`else
  localparam int SCORE_MAX  = 0;
`endif

  logic CLK = 1'b0;
  logic RST;

  factor_judge_if #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W), .PROB_W(PROB_W),
                    .SCORE_W(SCORE_W)) bus ();

  factor_judge #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W), .PROB_W(PROB_W),
                 .SCORE_W(SCORE_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int checks    = 0;
  int failures  = 0;
  int exp_score = 0;

  typedef struct {
    logic [11:0] prob;
    logic [23:0] word;
    int          err;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Verdict and start-to-done latency from the answer rules, one digit at a time.
  function automatic void model(input int prob, input logic [23:0] word,
                                output int err, output int lat);
    int prod = 1;
    int prev = 0;
    int cyc  = 0;
    int d;
    bit seen = 0;
    bit ovf  = 0;
    err = -1;
    lat = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      d = int'(word >> (DIGIT_W * (NUM_DIGITS - 1 - k))) & 15;
      cyc++;
      if (d == 0 && !seen) continue;
      if (d == 0) err = 2;
      else if (!(d inside {2, 3, 5, 7, 11, 13})) err = 1;
      else if (d < prev) err = 2;
      if (err >= 0) begin
        lat = cyc + 1;
        return;
      end
      prev = d;
      seen = 1;
      prod = prod * d;
      if (prod >= (1 << PROB_W)) ovf = 1;
      cyc += DIGIT_W;
    end
    err = (!seen || ovf || prod != prob) ? 3 : 0;
    lat = cyc + 2;
  endfunction

  task automatic run(input string name, input logic [11:0] prob, input logic [23:0] word,
                     input int exp_err, input int exp_lat, input int glitch_at);
    int cyc = 0;
    bit got = 0;
    int exp_hold;
    bus.problem = prob;
    bus.check   = word;
    bus.start   = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    chk({name, " busy after start"}, int'(bus.busy), 1);
    chk({name, " verdict cleared"}, int'({bus.done, bus.verdict_ok, bus.err_code}), 0);
    while (!got && cyc < BUDGET) begin
      if (cyc == glitch_at) begin
        bus.start   = 1'b1;
        bus.problem = ~prob;
        bus.check   = 24'h000001;
      end
      @(posedge CLK); #1;
      bus.start = 1'b0;
      cyc++;
      if (bus.done) got = 1;
    end
    if (!got) begin
      chk({name, " done timeout"}, 0, 1);
      return;
    end
    if (exp_err == 0 && exp_score < SCORE_MAX) exp_score++;
    chk({name, " latency"}, cyc, exp_lat);
    chk({name, " err_code"}, int'(bus.err_code), exp_err);
    chk({name, " verdict_ok"}, int'(bus.verdict_ok), (exp_err == 0) ? 1 : 0);
    chk({name, " busy at done"}, int'(bus.busy), 0);
    chk({name, " score"}, int'(bus.score), exp_score);
    @(posedge CLK); #1;
    exp_hold = ((exp_err == 0) ? 4 : 0) | exp_err;
    chk({name, " done one cycle"}, int'(bus.done), 0);
    chk({name, " verdict held"}, int'({bus.verdict_ok, bus.err_code}), exp_hold);
  endtask

  initial begin
    int          e;
    int          l;
    int          n;
    int          pi;
    int          prod;
    int          mode;
    int          pr[6];
    logic [11:0] prob;
    logic [23:0] word;
    bit          saw;

    pr = '{2, 3, 5, 7, 11, 13};
    vecs[0]  = '{12'h024, 24'h002233, 0, 24};
    vecs[1]  = '{12'h024, 24'h000001, 1, 7};
    vecs[2]  = '{12'h006, 24'h000032, 2, 11};
    vecs[3]  = '{12'h006, 24'h002030, 2, 9};
    vecs[4]  = '{12'h024, 24'h000235, 3, 20};
    vecs[5]  = '{12'hFFF, 24'hDDDDDD, 3, 32};
    vecs[6]  = '{12'h024, 24'h000000, 3, 8};
    vecs[7]  = '{12'h006, 24'h000023, 0, 16};
    vecs[8]  = '{12'h007, 24'h000007, 0, 12};
    vecs[9]  = '{12'h08F, 24'h0000BD, 0, 16};
    vecs[10] = '{12'h012, 24'h000029, 1, 11};
    vecs[11] = '{12'h005, 24'h000022, 3, 16};
    vecs[12] = '{12'h00F, 24'h00000F, 1, 7};

    bus.start   = 1'b0;
    bus.problem = '0;
    bus.check   = '0;
    RST         = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset verdict_ok", int'(bus.verdict_ok), 0);
    chk("reset err_code", int'(bus.err_code), 0);
    chk("reset score", int'(bus.score), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < 13; i++)
      run($sformatf("vec%0d", i), vecs[i].prob, vecs[i].word, vecs[i].err, vecs[i].lat, -1);

    // start pulses while busy must not disturb the judgement in flight
    run("restart early", 12'h024, 24'h002233, 0, 24, 0);
    run("restart mid", 12'h024, 24'h002233, 0, 24, 9);

    for (int r = 0; r < 40; r++) begin
      n    = $urandom_range(0, 4);
      pi   = 0;
      prod = 1;
      word = '0;
      for (int j = 0; j < n; j++) begin
        pi   = $urandom_range(5, pi);
        word = (word << 4) | 24'(pr[pi]);
        prod = prod * pr[pi];
      end
      prob = (prod < 4096) ? 12'(prod) : 12'($urandom);
      mode = $urandom_range(0, 3);
      if (mode == 1) prob = prob + 12'd1;
      if (mode == 2) word = 24'($urandom);
      if (mode == 3) word = word | (24'($urandom_range(15, 1)) << (4 * $urandom_range(5, 0)));
      model(int'(prob), word, e, l);
      run($sformatf("rand%0d", r), prob, word, e, l, -1);
    end

    // reset while multiplying aborts without a done pulse
    bus.problem = 12'h024;
    bus.check   = 24'h002233;
    bus.start   = 1'b1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("abort busy before reset", int'(bus.busy), 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_score = 0;
    chk("abort busy", int'(bus.busy), 0);
    chk("abort done", int'(bus.done), 0);
    chk("abort score", int'(bus.score), 0);
    chk("abort verdict", int'({bus.verdict_ok, bus.err_code}), 0);
    saw = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      if (bus.done || bus.busy) saw = 1;
    end
    chk("abort stays idle", int'(saw), 0);

    for (int i = 0; i < 4; i++)
      run($sformatf("score%0d", i), 12'h024, 24'h002233, 0, 24, -1);
    chk("score saturated", int'(bus.score), SCORE_MAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
